gamma_loader: RTL

//  Write-side companion of the 256x16 gamma lookup RAM.

---
 rtl/gamma_loader_if.sv | 23 ++
 rtl/gamma_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gamma_loader_if.sv
// Host byte stream and RAM write-port bundle for gamma_loader.
// master = stream source / RAM side, slave = loader.
interface gamma_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_ce;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output s_data, s_valid,
        input  s_ready, wr_ce, wr_addr, wr_data
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wr_ce, wr_addr, wr_data
    );
endinterface

// File: rtl/gamma_loader.sv
// Packs a little-endian byte stream into 16-bit gamma RAM entries written at 0..DEPTH-1.
// Optional trailing checksum check: define GAMMA_LOADER_CKSUM_EN.
module gamma_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    gamma_loader_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          table_valid,
    output logic          err
);
    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        DONE
`ifdef GAMMA_LOADER_CKSUM_EN
        ,
        CK_LO,
        CK_HI
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [7:0]        lo_q;
    logic              ready;
    logic              take;
`ifdef GAMMA_LOADER_CKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        busy  = (state != IDLE);
        case (state)
            LO, HI:    ready = 1'b1;
`ifdef GAMMA_LOADER_CKSUM_EN
            CK_LO, CK_HI: ready = 1'b1;
`endif
            DONE:      done  = 1'b1;
            default:   ;
        endcase
    end

    // start has priority over a byte offered in the same cycle
    assign take = bus.s_valid && ready && !start;

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = LO;
        end else begin
            case (state)
                LO:    if (take) state_nx = HI;
                HI:    if (take) state_nx = WRITE;
                WRITE: begin
                    if (addr == LAST_ADDR) begin
`ifdef GAMMA_LOADER_CKSUM_EN
                        state_nx = CK_LO;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        state_nx = LO;
                    end
                end
`ifdef GAMMA_LOADER_CKSUM_EN
                CK_LO: if (take) state_nx = CK_HI;
                CK_HI: if (take) state_nx = DONE;
`endif
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr        <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            lo_q        <= '0;
            table_valid <= 1'b0;
            err         <= 1'b0;
`ifdef GAMMA_LOADER_CKSUM_EN
            sum_q       <= '0;
`endif
        end else if (start) begin
            // a start while busy is an abort and leaves err set; from IDLE it clears err
            addr        <= '0;
            table_valid <= 1'b0;
            err         <= busy;
`ifdef GAMMA_LOADER_CKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            case (state)
                LO: if (take) lo_q <= bus.s_data;
                HI: begin
                    if (take) begin
                        wr_data_q <= {bus.s_data, lo_q};
                        wr_addr_q <= addr;
                    end
                end
                WRITE: begin
                    if (addr != LAST_ADDR) addr <= addr + 1'b1;
`ifdef GAMMA_LOADER_CKSUM_EN
                    sum_q <= sum_q + wr_data_q;
`endif
                end
`ifdef GAMMA_LOADER_CKSUM_EN
                CK_LO: if (take) lo_q <= bus.s_data;
                CK_HI: if (take && ({bus.s_data, lo_q} != sum_q)) err <= 1'b1;
`endif
                DONE: if (!err) table_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.s_ready = ready;
    assign bus.wr_ce   = (state == WRITE);
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule
